// File: rtl/bump_debouncer.sv
// bump_debouncer: debounce and edge-detect the RSLK bump switches.
//
// Every bumper pin goes through a 2-flop synchronizer and then gets its
// polarity fixed. A debounced level changes only after STABLE_TICKS
// consecutive sample ticks disagree with it. A free-running tick counter
// produces one sample tick every TICK_DIV sysclk cycles.
//
// Ports:
//   sysclk        system clock (12 MHz)
//   rst_n         asynchronous active-low reset
//   sw_raw        raw bumper pins, asynchronous to sysclk
//   sw_db         debounced level, 1 = pressed
//   press_pulse   one-cycle pulse on a debounced 0->1 transition
//   release_pulse one-cycle pulse on a debounced 1->0 transition
//   any_bump      combinational OR of sw_db
//   event_mask    sticky record of presses since the last acknowledge
//   event_valid   event_mask is nonzero
//   event_ready   consumer acknowledge (takes effect when event_valid is high)
//   press_count   saturating 16-bit total of presses (only with the option below)
//
// Optional feature: define BUMP_PRESS_COUNT_EN to add the press_count output.

module bump_debouncer #(
    parameter int unsigned NUM_SW       = 6,
    parameter int unsigned TICK_DIV     = 12000,
    parameter int unsigned STABLE_TICKS = 8,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_db,
    output logic [NUM_SW-1:0] press_pulse,
    output logic [NUM_SW-1:0] release_pulse,
    output logic              any_bump,
    output logic [NUM_SW-1:0] event_mask,
    output logic              event_valid,
    input  logic              event_ready
`ifdef BUMP_PRESS_COUNT_EN
    ,
    output logic [15:0]       press_count
`endif
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(STABLE_TICKS) + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);
    // Synchronizer reset value that reads as "not pressed" after polarity
    localparam logic [NUM_SW-1:0] SYNC_IDLE =
        (ACTIVE_LOW != 0) ? {NUM_SW{1'b1}} : {NUM_SW{1'b0}};

    logic [NUM_SW-1:0] sync1;
    logic [NUM_SW-1:0] sync2;
    logic [NUM_SW-1:0] lvl;
    logic [TW-1:0]     tcnt;
    logic [TW-1:0]     tcnt_nxt;
    logic              tick;
    logic [CW-1:0]     cnt     [NUM_SW];
    logic [CW-1:0]     cnt_nxt [NUM_SW];
    logic [NUM_SW-1:0] db_nxt;
    logic [NUM_SW-1:0] press_nxt;
    logic [NUM_SW-1:0] release_nxt;
    logic [NUM_SW-1:0] mask_nxt;
    logic              valid_nxt;

    // Polarity fix: lvl is 1 when the switch is pressed
    assign lvl      = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
    assign any_bump = |sw_db;

    // Sample-tick divider
    assign tick = (tcnt == TICK_LAST);

    always_comb begin
        tcnt_nxt = tcnt + TW'(1);
        if (tick) begin
            tcnt_nxt = '0;
        end
    end

    // Per-switch stability counters; only a tick can move a debounced level
    always_comb begin
        cnt_nxt     = cnt;
        db_nxt      = sw_db;
        press_nxt   = '0;
        release_nxt = '0;
        if (tick) begin
            for (int i = 0; i < int'(NUM_SW); i++) begin
                if (lvl[i] == sw_db[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db_nxt[i]      = lvl[i];
                    cnt_nxt[i]     = '0;
                    press_nxt[i]   = lvl[i];
                    release_nxt[i] = ~lvl[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Event latch: clearing by ack happens before new presses are ORed in,
    // so a press in the acknowledge cycle survives.
    always_comb begin
        mask_nxt  = ((event_valid & event_ready) ? '0 : event_mask) | press_pulse;
        valid_nxt = |mask_nxt;
    end

    // Register bank
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1         <= SYNC_IDLE;
            sync2         <= SYNC_IDLE;
            tcnt          <= '0;
            cnt           <= '{default: '0};
            sw_db         <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            event_mask    <= '0;
            event_valid   <= 1'b0;
        end else begin
            sync1         <= sw_raw;
            sync2         <= sync1;
            tcnt          <= tcnt_nxt;
            cnt           <= cnt_nxt;
            sw_db         <= db_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            event_mask    <= mask_nxt;
            event_valid   <= valid_nxt;
        end
    end

`ifdef BUMP_PRESS_COUNT_EN
    logic [16:0] pc_add;
    logic [16:0] pc_sum;
    logic [15:0] pc_nxt;

    // Saturating press total; a 17th bit catches the overflow
    always_comb begin
        pc_add = '0;
        for (int i = 0; i < int'(NUM_SW); i++) begin
            pc_add = pc_add + 17'(press_pulse[i]);
        end
        pc_sum = 17'(press_count) + pc_add;
        pc_nxt = pc_sum[16] ? 16'hFFFF : pc_sum[15:0];
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            press_count <= '0;
        end else begin
            press_count <= pc_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_bump_debouncer.sv
// tb_bump_debouncer: randomized and directed bench for bump_debouncer.
// A reference model, written as a sliding window of tick samples per switch,
// predicts every output each cycle.

module tb_bump_debouncer;

    localparam int unsigned NSW  = 6;
    localparam int unsigned TDIV = 10;
    localparam int unsigned ST   = 4;

    logic           sysclk;
    logic           rst_n;
    logic [NSW-1:0] sw_raw;
    logic [NSW-1:0] sw_db;
    logic [NSW-1:0] press_pulse;
    logic [NSW-1:0] release_pulse;
    logic           any_bump;
    logic [NSW-1:0] event_mask;
    logic           event_valid;
    logic           event_ready;
`ifdef BUMP_PRESS_COUNT_EN
    logic [15:0]    press_count;
`endif

    bump_debouncer #(
        .NUM_SW       (NSW),
        .TICK_DIV     (TDIV),
        .STABLE_TICKS (ST),
        .ACTIVE_LOW   (1)
    ) dut (
        .sysclk        (sysclk),
        .rst_n         (rst_n),
        .sw_raw        (sw_raw),
        .sw_db         (sw_db),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .any_bump      (any_bump),
        .event_mask    (event_mask),
        .event_valid   (event_valid),
        .event_ready   (event_ready)
`ifdef BUMP_PRESS_COUNT_EN
        ,
        .press_count   (press_count)
`endif
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_cyc;          // edges since reset release
    logic [NSW-1:0] m_p1, m_p2;     // pressed-level seen through two flops
    logic [ST-1:0]  m_win [NSW];    // most recent tick samples, newest in bit 0
    int            m_nsamp [NSW];  // tick samples since the last level change
    logic [NSW-1:0] m_db, m_press, m_rel, m_mask;
    logic           m_valid;
    logic           m_tick_last;
    int            m_count;

    task automatic model_reset();
        m_cyc = 0;
        m_p1 = '0; m_p2 = '0;
        m_db = '0; m_press = '0; m_rel = '0; m_mask = '0; m_valid = 1'b0;
        m_tick_last = 1'b0;
        m_count = 0;
        for (int i = 0; i < int'(NSW); i++) begin
            m_win[i] = '0;
            m_nsamp[i] = 0;
        end
    endtask

    // One clock edge, using the inputs that were present at that edge
    task automatic model_edge();
        logic [NSW-1:0] old_press, old_mask;
        logic           old_valid, tick;
        if (!rst_n) begin
            model_reset();
        end else begin
            tick = ((m_cyc % int'(TDIV)) == int'(TDIV) - 1);
            m_cyc++;
            m_tick_last = tick;
            old_press = m_press; old_mask = m_mask; old_valid = m_valid;
            m_press = '0; m_rel = '0;
            if (tick) begin
                for (int i = 0; i < int'(NSW); i++) begin
                    m_win[i] = {m_win[i][ST-2:0], m_p2[i]};
                    m_nsamp[i]++;
                    // Level flips once the last ST samples all disagree with it
                    if (m_nsamp[i] >= int'(ST) &&
                        m_win[i] == (m_db[i] ? {ST{1'b0}} : {ST{1'b1}})) begin
                        m_db[i] = ~m_db[i];
                        if (m_db[i]) m_press[i] = 1'b1;
                        else         m_rel[i]   = 1'b1;
                        m_nsamp[i] = 0;
                    end
                end
            end
            m_mask  = ((old_valid && event_ready) ? '0 : old_mask) | old_press;
            m_valid = (m_mask != 0);
            m_count = m_count + $countones(old_press);
            if (m_count > 65535) m_count = 65535;
            m_p2 = m_p1;
            m_p1 = ~sw_raw;
        end
    endtask

    task automatic compare_all();
        check("sw_db",         32'(sw_db),         32'(m_db));
        check("press_pulse",   32'(press_pulse),   32'(m_press));
        check("release_pulse", 32'(release_pulse), 32'(m_rel));
        check("any_bump",      32'(any_bump),      32'(|m_db));
        check("event_mask",    32'(event_mask),    32'(m_mask));
        check("event_valid",   32'(event_valid),   32'(m_valid));
`ifdef BUMP_PRESS_COUNT_EN
        check("press_count",   32'(press_count),   32'(m_count));
`endif
    endtask

    // Advance one clock, then check; inputs change only after this returns
    task automatic step();
        @(posedge sysclk);
        #1;
        model_edge();
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int qt;
        int n;
        bit done;

        rst_n = 1'b0;
        sw_raw = '1;
        event_ready = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (3) step();
        rst_n = 1'b1;

        // 1: idle pins, nothing happens
        repeat (200) step();
        check("s1_idle_db", 32'(sw_db), 32'h0);

        // 2: steady press on switch 0
        sw_raw[0] = 1'b0;
        repeat (80) step();
        check("s2_mask", 32'(event_mask), 32'h01);
        check("s2_any",  32'(any_bump),   32'h1);

        // 3: chatter on switch 2 never qualifies
        for (int k = 0; k < 10; k++) begin
            sw_raw[2] = ~sw_raw[2];
            repeat (15) step();
        end
        sw_raw[2] = 1'b1;
        repeat (60) step();
        check("s3_chatter_db", 32'(sw_db[2]), 32'h0);

        // 4: acknowledge in the same cycle as a new press on switch 3
        sw_raw[3] = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            step();
            if (m_press[3]) done = 1'b1;
        end
        check("s4_press_seen", 32'(done), 32'h1);
        event_ready = 1'b1;
        step();
        event_ready = 1'b0;
        check("s4_mask_kept",  32'(event_mask),  32'h08);
        check("s4_valid_kept", 32'(event_valid), 32'h1);
        event_ready = 1'b1;
        step();
        event_ready = 1'b0;
        check("s4_mask_clr",  32'(event_mask),  32'h00);
        check("s4_valid_clr", 32'(event_valid), 32'h0);

        // 5: reset in the middle of qualifying switch 1
        sw_raw[1] = 1'b0;
        qt = 0;
        for (int k = 0; k < 100 && qt < 2; k++) begin
            step();
            if (m_tick_last && m_win[1][0]) qt++;
        end
        check("s5_two_ticks", 32'(qt), 32'd2);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("s5_rst_db",    32'(sw_db),      32'h0);
        check("s5_rst_mask",  32'(event_mask), 32'h0);
        step();
        rst_n = 1'b1;
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            step();
            n++;
            if (m_db[1]) done = 1'b1;
        end
        check("s5_requal_cycles", 32'(n), 32'd40);

`ifdef BUMP_PRESS_COUNT_EN
        // 6: two switches pressed together add two at once
        begin
            int c0;
            sw_raw = '1;
            repeat (100) step();
            c0 = m_count;
            sw_raw[0] = 1'b0;
            sw_raw[5] = 1'b0;
            done = 1'b0;
            for (int k = 0; k < 100 && !done; k++) begin
                step();
                if (m_press != 0) done = 1'b1;
            end
            check("s6_both_pulse", 32'(press_pulse), 32'h21);
            step();
            check("s6_plus2", 32'(press_count), 32'(c0 + 2));
        end
`endif

        // Random phase: sparse pin flips and random acknowledges
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 24) == 0)
                sw_raw[$urandom_range(0, NSW - 1)] ^= 1'b1;
            event_ready = ($urandom_range(0, 7) == 0);
            step();
        end
        event_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
